// File: rtl/posix_time_pkg.sv
// Shared constants, FSM encodings and calendar helpers for the POSIX time decoder.
// Leap rule is only exact for years 1970..2106, which is all a 32-bit count reaches.
package posix_time_pkg;

    localparam logic [16:0] SEC_IN_DAY  = 17'd86400;
    localparam logic [16:0] SEC_IN_HOUR = 17'd3600;
    localparam logic [16:0] SEC_IN_MIN  = 17'd60;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DIV   = 3'd1;
    localparam logic [2:0] ST_HOUR  = 3'd2;
    localparam logic [2:0] ST_MIN   = 3'd3;
    localparam logic [2:0] ST_YEAR  = 3'd4;
    localparam logic [2:0] ST_MONTH = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    function automatic logic is_leap(input logic [15:0] year);
        return (year[1:0] == 2'd0) && (year != 16'd2100);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
        logic [4:0] len;
        case (month)
            4'd2:                        len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:     len = 5'd30;
            default:                     len = 5'd31;
        endcase
        return len;
    endfunction

    // Mod-7 add; increments never exceed 3 so a single subtract suffices.
    function automatic logic [2:0] wday_add(input logic [2:0] acc, input logic [1:0] inc);
        logic [3:0] sum;
        sum = {1'b0, acc} + {2'b00, inc};
        if (sum >= 4'd7) begin
            sum = sum - 4'd7;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/posix_div32.sv
// 32-by-17-bit restoring divider, one quotient bit per cycle, 32 cycles per divide.
// The first step runs on the start edge; done_o marks the final step with results valid.
module posix_div32
    import posix_time_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [16:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [16:0] remainder_o
);

    logic        running_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] quo_q;
    logic [16:0] rem_q;
    logic [16:0] div_q;

    logic [16:0] cur_rem;
    logic [16:0] cur_div;
    logic [31:0] cur_quo;
    logic        cur_bit;
    logic [17:0] trial;
    logic [17:0] diff;
    logic        take;
    logic [16:0] rem_step;
    logic [31:0] quo_step;

    always_comb begin
        cur_rem  = start_i ? 17'd0 : rem_q;
        cur_quo  = start_i ? 32'd0 : quo_q;
        cur_bit  = start_i ? dividend_i[31] : dvd_q[31];
        cur_div  = start_i ? divisor_i : div_q;
        trial    = {cur_rem, cur_bit};
        diff     = trial - {1'b0, cur_div};
        take     = trial >= {1'b0, cur_div};
        // Either branch is below the divisor, so bit 17 is always zero here.
        rem_step = take ? diff[16:0] : trial[16:0];
        quo_step = {cur_quo[30:0], take};
    end

    assign busy_o      = running_q;
    assign done_o      = running_q && (cnt_q == 5'd31) && !start_i;
    assign quotient_o  = done_o ? quo_step : quo_q;
    assign remainder_o = done_o ? rem_step : rem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            cnt_q     <= 5'd0;
            dvd_q     <= 32'd0;
            quo_q     <= 32'd0;
            rem_q     <= 17'd0;
            div_q     <= 17'd0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= 5'd1;
            dvd_q     <= {dividend_i[30:0], 1'b0};
            quo_q     <= quo_step;
            rem_q     <= rem_step;
            div_q     <= divisor_i;
        end else if (running_q) begin
            cnt_q <= cnt_q + 5'd1;
            dvd_q <= {dvd_q[30:0], 1'b0};
            quo_q <= quo_step;
            rem_q <= rem_step;
            if (cnt_q == 5'd31) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/posix_time_decoder.sv
// Multicycle POSIX seconds to calendar decoder: one divide by a day, then subtract
// loops for hours, minutes, years and months with a mod-7 weekday accumulator.
module posix_time_decoder
    import posix_time_pkg::*;
#(
    parameter int unsigned EPOCH_YEAR = 1970,
    parameter int unsigned EPOCH_WDAY = 4,
    parameter int unsigned YEAR_W     = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       posix_time_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [5:0]        sec_o,
    output logic [5:0]        min_o,
    output logic [4:0]        hour_o,
    output logic [4:0]        day_o,
    output logic [3:0]        month_o,
    output logic [YEAR_W-1:0] year_o,
    output logic [2:0]        wday_o
);

    logic [2:0]        state_q, state_d;
    logic [16:0]       rem_q, rem_d;
    logic [15:0]       days_q, days_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [2:0]        wacc_q, wacc_d;

    logic              valid_q, valid_d;
    logic [5:0]        sec_out_q, sec_out_d;
    logic [5:0]        min_out_q, min_out_d;
    logic [4:0]        hour_out_q, hour_out_d;
    logic [4:0]        day_out_q, day_out_d;
    logic [3:0]        month_out_q, month_out_d;
    logic [YEAR_W-1:0] year_out_q, year_out_d;
    logic [2:0]        wday_out_q, wday_out_d;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [31:0]       div_quo;
    logic [16:0]       div_rem;
    logic              unused_div;

    logic              leap_cur;
    logic [8:0]        ylen;
    logic [4:0]        mlen;
    logic [5:0]        wsum;

    assign div_start = (state_q == ST_IDLE) && start_i;

    posix_div32 u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (posix_time_i),
        .divisor_i   (SEC_IN_DAY),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Quotient never exceeds 49710 days, so the upper half is always zero.
    assign unused_div = ^div_quo[31:16] ^ div_busy;

    always_comb begin
        leap_cur = is_leap(16'(year_q));
        ylen     = leap_cur ? 9'd366 : 9'd365;
        mlen     = month_len(month_q, leap_cur);
        // Only reached in DONE where days is at most 30, so the sum stays below 37.
        wsum     = {3'b000, wacc_q} + {1'b0, days_q[4:0]};
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        days_d      = days_q;
        hour_d      = hour_q;
        min_d       = min_q;
        year_d      = year_q;
        month_d     = month_q;
        wacc_d      = wacc_q;
        valid_d     = 1'b0;
        sec_out_d   = sec_out_q;
        min_out_d   = min_out_q;
        hour_out_d  = hour_out_q;
        day_out_d   = day_out_q;
        month_out_d = month_out_q;
        year_out_d  = year_out_q;
        wday_out_d  = wday_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_DIV;
                    hour_d  = 5'd0;
                    min_d   = 6'd0;
                    year_d  = YEAR_W'(EPOCH_YEAR);
                    month_d = 4'd1;
                    wacc_d  = 3'(EPOCH_WDAY);
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    rem_d   = div_rem;
                    days_d  = div_quo[15:0];
                    state_d = ST_HOUR;
                end
            end
            ST_HOUR: begin
                if (rem_q >= SEC_IN_HOUR) begin
                    rem_d  = rem_q - SEC_IN_HOUR;
                    hour_d = hour_q + 5'd1;
                end else begin
                    state_d = ST_MIN;
                end
            end
            ST_MIN: begin
                if (rem_q >= SEC_IN_MIN) begin
                    rem_d = rem_q - SEC_IN_MIN;
                    min_d = min_q + 6'd1;
                end else begin
                    state_d = ST_YEAR;
                end
            end
            ST_YEAR: begin
                if (days_q >= {7'd0, ylen}) begin
                    days_d = days_q - {7'd0, ylen};
                    year_d = year_q + YEAR_W'(1);
                    wacc_d = wday_add(wacc_q, 2'(ylen - 9'd364));
                end else begin
                    state_d = ST_MONTH;
                end
            end
            ST_MONTH: begin
                if (days_q >= {11'd0, mlen}) begin
                    days_d  = days_q - {11'd0, mlen};
                    month_d = month_q + 4'd1;
                    wacc_d  = wday_add(wacc_q, 2'(mlen - 5'd28));
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b1;
                sec_out_d   = rem_q[5:0];
                min_out_d   = min_q;
                hour_out_d  = hour_q;
                day_out_d   = days_q[4:0] + 5'd1;
                month_out_d = month_q;
                year_out_d  = year_q;
                wday_out_d  = 3'(wsum % 6'd7);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= 17'd0;
            days_q      <= 16'd0;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            year_q      <= YEAR_W'(EPOCH_YEAR);
            month_q     <= 4'd1;
            wacc_q      <= 3'(EPOCH_WDAY);
            valid_q     <= 1'b0;
            sec_out_q   <= 6'd0;
            min_out_q   <= 6'd0;
            hour_out_q  <= 5'd0;
            day_out_q   <= 5'd1;
            month_out_q <= 4'd1;
            year_out_q  <= YEAR_W'(EPOCH_YEAR);
            wday_out_q  <= 3'(EPOCH_WDAY);
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            days_q      <= days_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            year_q      <= year_d;
            month_q     <= month_d;
            wacc_q      <= wacc_d;
            valid_q     <= valid_d;
            sec_out_q   <= sec_out_d;
            min_out_q   <= min_out_d;
            hour_out_q  <= hour_out_d;
            day_out_q   <= day_out_d;
            month_out_q <= month_out_d;
            year_out_q  <= year_out_d;
            wday_out_q  <= wday_out_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = valid_q;
    assign sec_o   = sec_out_q;
    assign min_o   = min_out_q;
    assign hour_o  = hour_out_q;
    assign day_o   = day_out_q;
    assign month_o = month_out_q;
    assign year_o  = year_out_q;
    assign wday_o  = wday_out_q;

endmodule

// File: tb/tb_posix_time_decoder.sv
// Directed bench for posix_time_decoder: calendar fields, latency, ignored starts,
// back-to-back starts and reset abort, all against hand-computed expectations.
module tb_posix_time_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] posix_time_i = 32'd0;
    logic        busy_o;
    logic        valid_o;
    logic [5:0]  sec_o;
    logic [5:0]  min_o;
    logic [4:0]  hour_o;
    logic [4:0]  day_o;
    logic [3:0]  month_o;
    logic [11:0] year_o;
    logic [2:0]  wday_o;

    int n_checks = 0;
    int n_errors = 0;
    int valid_seen = 0;

    posix_time_decoder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .posix_time_i (posix_time_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .sec_o        (sec_o),
        .min_o        (min_o),
        .hour_o       (hour_o),
        .day_o        (day_o),
        .month_o      (month_o),
        .year_o       (year_o),
        .wday_o       (wday_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (valid_o) valid_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Call #1 after a rising edge; returns the cycles from accept edge to valid_o.
    task automatic convert(input string tag, input logic [31:0] t, input int poke_at,
                           output int lat);
        posix_time_i = t;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        posix_time_i = 32'd0;
        check_eq({tag, ".busy"}, 64'(busy_o), 64'd1);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            if (i == poke_at) begin
                start_i = 1'b1;
                posix_time_i = 32'd5;
            end
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (valid_o) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check_eq({tag, ".timeout"}, 64'(valid_o), 64'd1);
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input int y, input int mo, input int d, input int h,
                                input int mi, input int s, input int wd);
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".busy_at_valid"}, 64'(busy_o), 64'd0);
        check_eq({tag, ".year"}, 64'(year_o), 64'(y));
        check_eq({tag, ".month"}, 64'(month_o), 64'(mo));
        check_eq({tag, ".day"}, 64'(day_o), 64'(d));
        check_eq({tag, ".hour"}, 64'(hour_o), 64'(h));
        check_eq({tag, ".min"}, 64'(min_o), 64'(mi));
        check_eq({tag, ".sec"}, 64'(sec_o), 64'(s));
        check_eq({tag, ".wday"}, 64'(wday_o), 64'(wd));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, ".valid"}, 64'(valid_o), 64'd0);
        check_eq({tag, ".hms"}, 64'({hour_o, min_o, sec_o}), 64'd0);
        check_eq({tag, ".day"}, 64'(day_o), 64'd1);
        check_eq({tag, ".month"}, 64'(month_o), 64'd1);
        check_eq({tag, ".year"}, 64'(year_o), 64'd1970);
        check_eq({tag, ".wday"}, 64'(wday_o), 64'd4);
    endtask

    initial begin
        int lat;
        int v0;

        repeat (2) @(posedge clk_i);
        #1;
        check_reset_vals("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        convert("t0", 32'd0, 0, lat);
        check_result("t0", lat, 36, 1970, 1, 1, 0, 0, 0, 4);

        repeat (3) @(posedge clk_i);
        #1;
        convert("eod", 32'd86399, 0, lat);
        check_result("eod", lat, 118, 1970, 1, 1, 23, 59, 59, 4);

        // Fields must hold while idle.
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("hold.hour", 64'(hour_o), 64'd23);

        convert("leap2000", 32'd951782400, 0, lat);
        check_result("leap2000", lat, 67, 2000, 2, 29, 0, 0, 0, 2);

        convert("feb2100", 32'd4107542399, 0, lat);
        check_result("feb2100", lat, 249, 2100, 2, 28, 23, 59, 59, 0);
        // Started in the valid_o cycle of the previous conversion.
        convert("mar2100", 32'd4107542400, 0, lat);
        check_result("mar2100", lat, 168, 2100, 3, 1, 0, 0, 0, 1);

        repeat (2) @(posedge clk_i);
        #1;
        v0 = valid_seen;
        convert("max", 32'hFFFF_FFFF, 20, lat);
        check_result("max", lat, 207, 2106, 2, 7, 6, 28, 15, 0);
        repeat (4) @(posedge clk_i);
        #1;
        check_eq("max.one_valid", 64'(valid_seen - v0), 64'd1);
        check_eq("max.idle_after", 64'(busy_o), 64'd0);

        // Abort during the year loop.
        v0 = valid_seen;
        posix_time_i = 32'd1234567890;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #1;
        check_eq("abort.busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (300) @(posedge clk_i);
        #1;
        check_eq("abort.no_valid", 64'(valid_seen - v0), 64'd0);
        check_eq("abort.idle", 64'(busy_o), 64'd0);

        convert("restart", 32'd1234567890, 0, lat);
        check_result("restart", lat, 130, 2009, 2, 13, 23, 31, 30, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
